// File: rtl/forward_unit.sv
// EX-stage operand forwarding and load-use hazard detection for a 5-stage pipeline.
// Tracks {valid, rd, regwrite, memread} through EX/MEM/WB and registers mux selects for EX.
module forward_unit #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rn,
  input  logic [REG_BITS-1:0] id_rm,
  input  logic                id_use_rn,
  input  logic                id_use_rm,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                flush,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                stall,
  output logic [CNT_BITS-1:0] stall_count
);

  localparam logic [REG_BITS-1:0] ZERO_REG = '1;

  // Stage records: _p0 = EX, _p1 = MEM, _p2 = WB
  logic                vld_p0, regwrite_p0, memread_p0;
  logic                vld_p1, regwrite_p1, memread_p1;
  logic                vld_p2, regwrite_p2, memread_p2;
  logic [REG_BITS-1:0] rd_p0, rd_p1, rd_p2;

  logic       ex_prod, mem_prod, take;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    sat_inc = (v == '1) ? v : v + CNT_BITS'(1);
  endfunction

  // EX/MEM result wins over MEM/WB when both hold the register.
  function automatic logic [1:0] pick_src(
    input logic                use_src,
    input logic [REG_BITS-1:0] src,
    input logic                ex_p,
    input logic [REG_BITS-1:0] ex_rd,
    input logic                mem_p,
    input logic [REG_BITS-1:0] mem_rd
  );
    pick_src = 2'b00;
    if (use_src && (src != ZERO_REG)) begin
      if (ex_p && (ex_rd == src))        pick_src = 2'b01;
      else if (mem_p && (mem_rd == src)) pick_src = 2'b10;
    end
  endfunction

  always_comb begin
    ex_prod   = vld_p0 && regwrite_p0 && (rd_p0 != ZERO_REG);
    mem_prod  = vld_p1 && regwrite_p1 && (rd_p1 != ZERO_REG);
    stall     = id_valid && !flush && ex_prod && memread_p0 &&
                ((id_use_rn && (id_rn == rd_p0)) || (id_use_rm && (id_rm == rd_p0)));
    take      = id_valid && !stall && !flush;
    fwd_a_nxt = 2'b00;
    fwd_b_nxt = 2'b00;
    if (take) begin
      fwd_a_nxt = pick_src(id_use_rn, id_rn, ex_prod, rd_p0, mem_prod, rd_p1);
      fwd_b_nxt = pick_src(id_use_rm, id_rm, ex_prod, rd_p0, mem_prod, rd_p1);
    end
  end

  // Decode -> EX -> MEM -> WB control, selects and stall counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0      <= 1'b0;
      regwrite_p0 <= 1'b0;
      memread_p0  <= 1'b0;
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      vld_p2      <= 1'b0;
      regwrite_p2 <= 1'b0;
      memread_p2  <= 1'b0;
      fwd_a       <= 2'b00;
      fwd_b       <= 2'b00;
      stall_count <= '0;
    end else begin
      vld_p0      <= take;
      regwrite_p0 <= id_regwrite;
      memread_p0  <= id_memread;
      vld_p1      <= vld_p0;
      regwrite_p1 <= regwrite_p0;
      memread_p1  <= memread_p0;
      vld_p2      <= vld_p1;
      regwrite_p2 <= regwrite_p1;
      memread_p2  <= memread_p1;
      fwd_a       <= fwd_a_nxt;
      fwd_b       <= fwd_b_nxt;
      if (stall) stall_count <= sat_inc(stall_count);
    end
  end

  // Register indices are qualified by the valid bits, so they need no reset
  always_ff @(posedge clk) begin
    rd_p0 <= id_rd;
    rd_p1 <= rd_p0;
    rd_p2 <= rd_p1;
  end

endmodule

// File: tb/tb_forward_unit.sv
// Bench for forward_unit: directed hazard scenarios plus random traffic against a history-based model.
module tb_forward_unit;

  localparam int RB   = 5;
  localparam int CB   = 4;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          id_valid = 1'b0;
  logic [RB-1:0] id_rn = '0, id_rm = '0, id_rd = '0;
  logic          id_use_rn = 1'b0, id_use_rm = 1'b0;
  logic          id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall;
  logic [CB-1:0] stall_count;

  forward_unit #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; int rd; bit rw; bit mr;} ins_t;

  // hist[0] = instruction now in EX, hist[1] = MEM, hist[2] = WB
  ins_t hist[$];
  int   cnt;
  int   total = 0;
  int   bad = 0;

  task automatic check_val(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit producer(input ins_t e);
    return e.v && e.rw && (e.rd != 31);
  endfunction

  function automatic int exp_sel(input bit use_src, input int r);
    if (!use_src || r == 31) return 0;
    if (producer(hist[0]) && hist[0].rd == r) return 1;
    if (producer(hist[1]) && hist[1].rd == r) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    ins_t b;
    b = '{v: 0, rd: 0, rw: 0, mr: 0};
    hist = {b, b, b};
    cnt = 0;
  endtask

  // Present one decode slot for one clock and check stall, selects and count.
  task automatic step(input bit v, input int rn, input int rm, input bit urn, input bit urm,
                      input int rd, input bit rw, input bit mr, input bit fl);
    bit   es, take;
    int   nfa, nfb, ncnt;
    ins_t ni;
    id_valid = v; id_rn = RB'(rn); id_rm = RB'(rm); id_use_rn = urn; id_use_rm = urm;
    id_rd = RB'(rd); id_regwrite = rw; id_memread = mr; flush = fl;
    @(negedge clk);
    es = v && !fl && producer(hist[0]) && hist[0].mr &&
         ((urn && rn == hist[0].rd) || (urm && rm == hist[0].rd));
    check_val("stall", int'(stall), int'(es));
    take = v && !es && !fl;
    nfa  = take ? exp_sel(urn, rn) : 0;
    nfb  = take ? exp_sel(urm, rm) : 0;
    ncnt = (es && cnt < CMAX) ? cnt + 1 : cnt;
    ni   = take ? '{v: 1, rd: rd, rw: rw, mr: mr} : '{v: 0, rd: 0, rw: 0, mr: 0};
    @(posedge clk);
    #1;
    hist = {ni, hist[0], hist[1]};
    cnt  = ncnt;
    check_val("fwd_a", int'(fwd_a), nfa);
    check_val("fwd_b", int'(fwd_b), nfb);
    check_val("stall_count", int'(stall_count), cnt);
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int regs[5] = '{1, 2, 3, 7, 31};

  initial begin
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_val("rst_stall", int'(stall), 0);
      check_val("rst_fwd_a", int'(fwd_a), 0);
      check_val("rst_fwd_b", int'(fwd_b), 0);
      check_val("rst_count", int'(stall_count), 0);
    end
    @(posedge clk);
    #1 reset = 1'b1;

    // ADD X1 ; ADD X2,X1,X3
    step(1, 2, 3, 1, 1, 1, 1, 0, 0);
    step(1, 1, 3, 1, 1, 2, 1, 0, 0);
    check_val("add_add_a", int'(fwd_a), 1);
    check_val("add_add_b", int'(fwd_b), 0);
    nop(); nop();

    // ADD X1 ; NOP ; SUB X4,X5,X1
    step(1, 2, 3, 1, 1, 1, 1, 0, 0);
    nop();
    step(1, 5, 1, 1, 1, 4, 1, 0, 0);
    check_val("memwb_b", int'(fwd_b), 2);
    nop(); nop();
    // ADD X1 ; ADD X1 ; SUB X4,X5,X1
    step(1, 2, 3, 1, 1, 1, 1, 0, 0);
    step(1, 2, 3, 1, 1, 1, 1, 0, 0);
    step(1, 5, 1, 1, 1, 4, 1, 0, 0);
    check_val("prio_b", int'(fwd_b), 1);
    nop(); nop();

    // LDUR X7 ; ADD X8,X7,X7
    step(1, 2, 0, 1, 0, 7, 1, 1, 0);
    step(1, 7, 7, 1, 1, 8, 1, 0, 0);
    check_val("lu_bubble_a", int'(fwd_a), 0);
    check_val("lu_bubble_b", int'(fwd_b), 0);
    step(1, 7, 7, 1, 1, 8, 1, 0, 0);
    check_val("lu_fwd_a", int'(fwd_a), 2);
    check_val("lu_fwd_b", int'(fwd_b), 2);
    check_val("lu_count", int'(stall_count), 1);
    nop(); nop();

    // X31 producers never forward nor stall
    step(1, 2, 3, 1, 1, 31, 1, 0, 0);
    step(1, 31, 31, 1, 1, 4, 1, 0, 0);
    check_val("xzr_add_a", int'(fwd_a), 0);
    step(1, 2, 0, 1, 0, 31, 1, 1, 0);
    step(1, 31, 31, 1, 1, 4, 1, 0, 0);
    check_val("xzr_ld_b", int'(fwd_b), 0);
    nop(); nop();

    // load-use with flush in the same cycle
    step(1, 2, 0, 1, 0, 7, 1, 1, 0);
    step(1, 7, 7, 1, 1, 8, 1, 0, 1);
    check_val("flush_a", int'(fwd_a), 0);
    check_val("flush_count", int'(stall_count), 1);
    nop(); nop();

    // repeated LDUR X7,[X7] stalls every other cycle until the counter saturates
    for (int i = 0; i < 2 * ((1 << CB) + 3); i++) step(1, 7, 0, 1, 0, 7, 1, 1, 0);
    check_val("sat_count", int'(stall_count), CMAX);
    nop(); nop();

    // reset asserted during a stall clears everything without a clock edge
    step(1, 2, 3, 1, 1, 7, 1, 0, 0);
    step(1, 7, 0, 1, 0, 7, 1, 1, 0);
    check_val("pre_rst_a", int'(fwd_a), 1);
    id_valid = 1; id_rn = 5'd7; id_rm = 5'd7; id_use_rn = 1; id_use_rm = 1;
    id_rd = 5'd8; id_regwrite = 1; id_memread = 0; flush = 0;
    @(negedge clk);
    check_val("pre_rst_stall", int'(stall), 1);
    #2 reset = 1'b0;
    #1;
    check_val("async_stall", int'(stall), 0);
    check_val("async_fwd_a", int'(fwd_a), 0);
    check_val("async_fwd_b", int'(fwd_b), 0);
    check_val("async_count", int'(stall_count), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    // first edge after release takes the held reader with no producers around
    step(1, 7, 7, 1, 1, 8, 1, 0, 0);
    check_val("post_rst_a", int'(fwd_a), 0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(9, 0) < 8,
           regs[$urandom_range(4, 0)], regs[$urandom_range(4, 0)],
           $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
           regs[$urandom_range(4, 0)],
           $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0,
           $urandom_range(9, 0) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
